// File: rtl/wm8978_i2c_slave.sv
// WM8978 control-port model: write-only I2C slave that stores {addr[6:0], data[8:0]}
// frames in a 64 x 9 register file and exposes a registered read port.
module wm8978_i2c_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         FILT     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       reg_wr,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  input  logic [5:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE, DEV, ACK_DEV, BYTE1, ACK1, BYTE2, ACK2, IGNORE
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] raw_in, filt_lvl, filt_prev_reg;
  logic       scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] bit_cnt_reg;
  logic       done_reg;
  logic [7:0] shift_reg, byte1_reg;
  logic       commit, abort;
  logic       reg_wr_reg, err_reg;
  logic [6:0] reg_addr_reg;
  logic [8:0] reg_data_reg, rd_data_reg;
  logic [8:0] regs_word [64];

  assign raw_in = {sda_in, scl};

  // Bit 0 = SCL, bit 1 = SDA: synchronize, then accept a new level only once
  // the last FILT synchronized samples all agree.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cond
      logic            sync1_reg, sync2_reg, lvl_reg;
      logic [FILT-1:0] hist_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          hist_reg  <= '1;
          lvl_reg   <= 1'b1;
        end else begin
          sync1_reg <= raw_in[gi];
          sync2_reg <= sync1_reg;
          hist_reg  <= (hist_reg << 1) | FILT'(sync2_reg);
          if (&hist_reg)
            lvl_reg <= 1'b1;
          else if (~|hist_reg)
            lvl_reg <= 1'b0;
        end
      end
      assign filt_lvl[gi] = lvl_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) filt_prev_reg <= 2'b11;
    else     filt_prev_reg <= filt_lvl;
  end

  assign scl_f     = filt_lvl[0];
  assign sda_f     = filt_lvl[1];
  assign scl_rise  = scl_f & ~filt_prev_reg[0];
  assign scl_fall  = ~scl_f & filt_prev_reg[0];
  assign start_det = scl_f & filt_prev_reg[0] & filt_prev_reg[1] & ~sda_f;
  assign stop_det  = scl_f & filt_prev_reg[0] & ~filt_prev_reg[1] & sda_f;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (start_det)
      state_next = DEV;
    else if (stop_det)
      state_next = IDLE;
    else begin
      case (state_reg)
        DEV:     if (scl_fall && done_reg)
                   state_next = (shift_reg == {DEV_ADDR, 1'b0}) ? ACK_DEV : IGNORE;
        BYTE1:   if (scl_fall && done_reg)
                   state_next = shift_reg[7] ? IGNORE : ACK1;
        BYTE2:   if (scl_fall && done_reg) state_next = ACK2;
        ACK_DEV: if (scl_fall) state_next = BYTE1;
        ACK1:    if (scl_fall) state_next = BYTE2;
        ACK2:    if (scl_fall) state_next = IGNORE;
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    sda_oe = 1'b0;
    busy   = 1'b0;
    if (state_reg == ACK_DEV || state_reg == ACK1 || state_reg == ACK2)
      sda_oe = 1'b1;
    if (state_reg != IDLE)
      busy = 1'b1;
  end

  assign commit = (state_reg == BYTE2) && (state_next == ACK2);
  assign abort  = (start_det || stop_det) &&
                  (state_reg == BYTE1 || state_reg == ACK1 || state_reg == BYTE2);

  // Shift register and bit counter; done_reg marks a full byte awaiting its ACK slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg <= '0;
      done_reg    <= 1'b0;
      shift_reg   <= '0;
      byte1_reg   <= '0;
    end else if (start_det || stop_det) begin
      bit_cnt_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      if ((state_reg == DEV || state_reg == BYTE1 || state_reg == BYTE2) &&
          scl_rise && !done_reg) begin
        shift_reg   <= {shift_reg[6:0], sda_f};
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7)
          done_reg <= 1'b1;
      end
      if ((state_reg == ACK_DEV || state_reg == ACK1 || state_reg == ACK2) && scl_fall) begin
        bit_cnt_reg <= '0;
        done_reg    <= 1'b0;
      end
      if (state_reg == BYTE1 && state_next == ACK1)
        byte1_reg <= shift_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wr_reg   <= 1'b0;
      err_reg      <= 1'b0;
      reg_addr_reg <= '0;
      reg_data_reg <= '0;
    end else begin
      reg_wr_reg <= commit;
      err_reg    <= abort;
      if (commit) begin
        reg_addr_reg <= byte1_reg[7:1];
        reg_data_reg <= {byte1_reg[0], shift_reg};
      end
    end
  end

  // Address 0 is the codec soft reset: it clears the whole file, itself included.
  generate
    for (gi = 0; gi < 64; gi++) begin : g_regs
      logic [8:0] val_reg;
      always_ff @(posedge clk) begin
        if (rst)
          val_reg <= '0;
        else if (reg_wr_reg) begin
          if (reg_addr_reg == 7'd0)
            val_reg <= '0;
          else if (reg_addr_reg[5:0] == 6'(gi))
            val_reg <= reg_data_reg;
        end
      end
      assign regs_word[gi] = val_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) rd_data_reg <= '0;
    else     rd_data_reg <= regs_word[rd_addr];
  end

  assign reg_wr   = reg_wr_reg;
  assign reg_addr = reg_addr_reg;
  assign reg_data = reg_data_reg;
  assign rd_data  = rd_data_reg;
  assign err      = err_reg;

endmodule
